// File: rtl/pulse_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_cond_pkg
// Description : Shared constants for the pulse input conditioner: the 2-bit
//               qualification FSM state encodings and the minimum synchroniser
//               depth.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_cond_pkg;

  // Qualification FSM states
  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_QUAL_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_QUAL_LOW  = 2'd3;

  // Shallowest synchroniser that still gives metastability protection
  localparam int MIN_SYNC_STAGES = 2;

endpackage : pulse_cond_pkg
`default_nettype wire

// File: rtl/pulse_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_chain
// Description : Multi-flop synchroniser bringing an asynchronous single-bit
//               input into the clk domain.
// Ports       : clk       - destination clock
//               rst_n     - asynchronous active-low reset, clears the chain
//               async_in  - asynchronous input bit
//               sync_out  - synchronised bit (last flop of the chain)
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_chain
  import pulse_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  // An illegal depth below the minimum is clamped rather than built short
  localparam int c_stages = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES
                                                            : SYNC_STAGES;

  logic [c_stages-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[c_stages-2:0], async_in};
    end
  end

  assign sync_out = r_chain[c_stages-1];

endmodule : pulse_sync_chain
`default_nettype wire

// File: rtl/pulse_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pulse_input_conditioner
// Description : Front end for the pulse length converter. Synchronises the
//               raw pulse input, glitch-filters it with a programmable
//               qualification time, and produces registered rise / fall
//               strobes. A programmable holdoff after each accepted rise
//               turns further rises into "rejected" strobes.
// Ports       : IN_CLOCK           - single clock
//               IN_RESET_N         - asynchronous active-low reset
//               IN_RAW_PULSE       - raw pulse, asynchronous to IN_CLOCK
//               IN_FILTER_CLKS     - qualification length N (live)
//               IN_HOLDOFF_CLKS    - holdoff length H (loaded on accepted rise)
//               OUT_FILTERED_LEVEL - debounced level
//               OUT_RISE_PULSE     - strobe on accepted, non-held-off rise
//               OUT_FALL_PULSE     - strobe on accepted fall
//               OUT_REJECTED_PULSE - strobe on rise accepted during holdoff
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_input_conditioner
  import pulse_cond_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_BITS  = 4,
  parameter int HOLDOFF_BITS = 3
) (
  input  logic                    IN_CLOCK,
  input  logic                    IN_RESET_N,
  input  logic                    IN_RAW_PULSE,
  input  logic [FILTER_BITS-1:0]  IN_FILTER_CLKS,
  input  logic [HOLDOFF_BITS-1:0] IN_HOLDOFF_CLKS,
  output logic                    OUT_FILTERED_LEVEL,
  output logic                    OUT_RISE_PULSE,
  output logic                    OUT_FALL_PULSE,
  output logic                    OUT_REJECTED_PULSE
);

  localparam logic [FILTER_BITS-1:0]  c_cnt_one  = {{(FILTER_BITS-1){1'b0}}, 1'b1};
  localparam logic [HOLDOFF_BITS-1:0] c_hold_one = {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};

  logic                    w_s;
  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [FILTER_BITS-1:0]  r_cnt;
  logic [FILTER_BITS-1:0]  w_cnt_nxt;
  logic [HOLDOFF_BITS-1:0] r_hold;
  logic                    w_acc_rise;
  logic                    w_acc_fall;
  logic                    w_hold_idle;
  logic                    r_level;
  logic                    r_rise;
  logic                    r_fall;
  logic                    r_rej;

  pulse_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (IN_CLOCK),
    .rst_n    (IN_RESET_N),
    .async_in (IN_RAW_PULSE),
    .sync_out (w_s)
  );

  // Qualification FSM. The counter holds how many differing samples have
  // been seen; ">=" lets a lowered N complete immediately instead of
  // waiting for a counter that has already passed it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_rise  = 1'b0;
    w_acc_fall  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_s) begin
          if (IN_FILTER_CLKS == '0) begin
            w_acc_rise = 1'b1;
          end else begin
            w_cnt_nxt   = c_cnt_one;
            w_state_nxt = ST_QUAL_HIGH;
          end
        end
      end
      ST_QUAL_HIGH: begin
        if (!w_s) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_LOW;
        end else if (r_cnt >= IN_FILTER_CLKS) begin
          w_acc_rise = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      ST_HIGH: begin
        if (!w_s) begin
          if (IN_FILTER_CLKS == '0) begin
            w_acc_fall = 1'b1;
          end else begin
            w_cnt_nxt   = c_cnt_one;
            w_state_nxt = ST_QUAL_LOW;
          end
        end
      end
      ST_QUAL_LOW: begin
        if (w_s) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HIGH;
        end else if (r_cnt >= IN_FILTER_CLKS) begin
          w_acc_fall = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_LOW;
      end
    endcase

    if (w_acc_rise) begin
      w_state_nxt = ST_HIGH;
      w_cnt_nxt   = '0;
    end
    if (w_acc_fall) begin
      w_state_nxt = ST_LOW;
      w_cnt_nxt   = '0;
    end
  end

  // Holdoff decision uses the counter value from before this edge
  assign w_hold_idle = (r_hold == '0);

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;

      // Reload beats decrement; counter saturates at zero
      if (w_acc_rise && w_hold_idle) begin
        r_hold <= IN_HOLDOFF_CLKS;
      end else if (!w_hold_idle) begin
        r_hold <= r_hold - c_hold_one;
      end

      if (w_acc_rise) begin
        r_level <= 1'b1;
      end else if (w_acc_fall) begin
        r_level <= 1'b0;
      end

      r_rise <= w_acc_rise && w_hold_idle;
      r_rej  <= w_acc_rise && !w_hold_idle;
      r_fall <= w_acc_fall;
    end
  end

  assign OUT_FILTERED_LEVEL = r_level;
  assign OUT_RISE_PULSE     = r_rise;
  assign OUT_FALL_PULSE     = r_fall;
  assign OUT_REJECTED_PULSE = r_rej;

endmodule : pulse_input_conditioner
`default_nettype wire

// File: tb/tb_pulse_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_input_conditioner
// Description : Directed self-checking bench for pulse_input_conditioner.
//               Inputs change 1 time unit after a rising edge; outputs are
//               sampled at the same point. Tick i is the i-th rising edge
//               after the stimulus for a scenario starts; observed vector
//               is {level, rise, fall, rejected}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_input_conditioner;

  localparam int SYNC_STAGES  = 2;
  localparam int FILTER_BITS  = 4;
  localparam int HOLDOFF_BITS = 3;

  logic                    IN_CLOCK;
  logic                    IN_RESET_N;
  logic                    IN_RAW_PULSE;
  logic [FILTER_BITS-1:0]  IN_FILTER_CLKS;
  logic [HOLDOFF_BITS-1:0] IN_HOLDOFF_CLKS;
  logic                    OUT_FILTERED_LEVEL;
  logic                    OUT_RISE_PULSE;
  logic                    OUT_FALL_PULSE;
  logic                    OUT_REJECTED_PULSE;

  int compared;
  int mismatched;

  pulse_input_conditioner #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_BITS  (FILTER_BITS),
    .HOLDOFF_BITS (HOLDOFF_BITS)
  ) dut (
    .IN_CLOCK           (IN_CLOCK),
    .IN_RESET_N         (IN_RESET_N),
    .IN_RAW_PULSE       (IN_RAW_PULSE),
    .IN_FILTER_CLKS     (IN_FILTER_CLKS),
    .IN_HOLDOFF_CLKS    (IN_HOLDOFF_CLKS),
    .OUT_FILTERED_LEVEL (OUT_FILTERED_LEVEL),
    .OUT_RISE_PULSE     (OUT_RISE_PULSE),
    .OUT_FALL_PULSE     (OUT_FALL_PULSE),
    .OUT_REJECTED_PULSE (OUT_REJECTED_PULSE)
  );

  initial IN_CLOCK = 1'b0;
  always #5 IN_CLOCK = ~IN_CLOCK;

  task automatic tick();
    @(posedge IN_CLOCK);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {OUT_FILTERED_LEVEL, OUT_RISE_PULSE, OUT_FALL_PULSE, OUT_REJECTED_PULSE};
  endfunction

  // Reset held with raw toggling, then released with raw low: silence
  task automatic test_reset();
    logic [3:0] obs;
    IN_RESET_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      IN_RAW_PULSE = ~IN_RAW_PULSE;
      tick();
      obs = outs();
      compared++;
      if (obs !== 4'b0000) begin
        mismatched++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs, 4'b0000);
      end
    end
    IN_RAW_PULSE = 1'b0;
    IN_RESET_N   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      obs = outs();
      compared++;
      if (obs !== 4'b0000) begin
        mismatched++;
        $display("FAIL reset_release tick %0d: got %b want %b", i, obs, 4'b0000);
      end
    end
  endtask

  // N=3: raw high for 20 samples -> rise on tick 6, fall on tick 26
  task automatic test_qualified_pulse();
    logic [3:0] obs;
    logic [3:0] exp;
    IN_FILTER_CLKS  = 4'd3;
    IN_HOLDOFF_CLKS = 3'd0;
    for (int i = 1; i <= 32; i++) begin
      IN_RAW_PULSE = (i <= 20);
      tick();
      exp = {(i >= 6 && i < 26), (i == 6), (i == 26), 1'b0};
      obs = outs();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL qualified_pulse tick %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  // N=3: only three high samples -> glitch discarded
  task automatic test_glitch();
    logic [3:0] obs;
    IN_FILTER_CLKS = 4'd3;
    for (int i = 1; i <= 12; i++) begin
      IN_RAW_PULSE = (i <= 3);
      tick();
      obs = outs();
      compared++;
      if (obs !== 4'b0000) begin
        mismatched++;
        $display("FAIL glitch tick %0d: got %b want %b", i, obs, 4'b0000);
      end
    end
  endtask

  // N=0: a single-cycle raw pulse passes straight through
  task automatic test_no_filter();
    logic [3:0] obs;
    logic [3:0] exp;
    IN_FILTER_CLKS  = 4'd0;
    IN_HOLDOFF_CLKS = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      IN_RAW_PULSE = (i == 1);
      tick();
      exp = {(i == 3), (i == 3), (i == 4), 1'b0};
      obs = outs();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL no_filter tick %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  // N=0, H=5: rises on ticks 3, 6, 9. Holdoff loaded 5 at tick 3 is 3 at
  // tick 6 (rejected) and has reached 0 at tick 8, so tick 9 is a rise.
  task automatic test_back_to_back();
    logic [3:0] obs;
    logic [3:0] exp;
    IN_FILTER_CLKS  = 4'd0;
    IN_HOLDOFF_CLKS = 3'd5;
    for (int i = 1; i <= 16; i++) begin
      IN_RAW_PULSE = (i == 1 || i == 4 || i == 7);
      tick();
      exp = {(i == 3 || i == 6 || i == 9),
             (i == 3 || i == 9),
             (i == 4 || i == 7 || i == 10),
             (i == 6)};
      obs = outs();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL back_to_back tick %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  // N=2, raw held high: rise on tick 5; async reset mid-cycle clears the
  // level at once; after release a fresh qualified rise follows on tick 5
  task automatic test_async_reset();
    logic [3:0] obs;
    logic [3:0] exp;
    IN_FILTER_CLKS  = 4'd2;
    IN_HOLDOFF_CLKS = 3'd0;
    IN_RAW_PULSE    = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i >= 5), (i == 5), 1'b0, 1'b0};
      obs = outs();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL async_pre tick %0d: got %b want %b", i, obs, exp);
      end
    end
    #3;
    IN_RESET_N = 1'b0;
    #1;
    obs = outs();
    compared++;
    if (obs !== 4'b0000) begin
      mismatched++;
      $display("FAIL async_assert: got %b want %b", obs, 4'b0000);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      obs = outs();
      compared++;
      if (obs !== 4'b0000) begin
        mismatched++;
        $display("FAIL async_held tick %0d: got %b want %b", i, obs, 4'b0000);
      end
    end
    IN_RESET_N = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i >= 5), (i == 5), 1'b0, 1'b0};
      obs = outs();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL async_post tick %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    IN_RESET_N      = 1'b0;
    IN_RAW_PULSE    = 1'b0;
    IN_FILTER_CLKS  = 4'd0;
    IN_HOLDOFF_CLKS = 3'd0;
    #1;
    test_reset();
    test_qualified_pulse();
    test_glitch();
    test_no_filter();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pulse_input_conditioner
`default_nettype wire

// File: doc/pulse_input_conditioner.md
Name: pulse_input_conditioner

Overview:
Front-end stage for the pulse length converter. It synchronises an asynchronous raw pulse input and glitch-filters it with a programmable qualification time. Its rising-edge strobe drives the converter's IN_PULSE input. A programmable holdoff after each accepted rise suppresses re-triggering and flags rejected rises.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range 2 or more.
FILTER_BITS, 4, width of IN_FILTER_CLKS and the qualification counter.
HOLDOFF_BITS, 3, width of IN_HOLDOFF_CLKS and the holdoff counter.

Ports:
IN_CLOCK  input  1  single clock for the whole block.
IN_RESET_N  input  1  reset, asynchronous, active-low.
IN_RAW_PULSE  input  1  raw pulse input, asynchronous to IN_CLOCK.
IN_FILTER_CLKS  input  FILTER_BITS  qualification length N; sampled live every cycle.
IN_HOLDOFF_CLKS  input  HOLDOFF_BITS  holdoff length H; loaded on each accepted rise.
OUT_FILTERED_LEVEL  output  1  registered, debounced level.
OUT_RISE_PULSE  output  1  one-cycle strobe on an accepted, non-held-off rise.
OUT_FALL_PULSE  output  1  one-cycle strobe on an accepted fall.
OUT_REJECTED_PULSE  output  1  one-cycle strobe on a rise accepted during holdoff.

Behaviour:
- Reset (asynchronous, active-low):
  - Sync flops, qualification counter and holdoff counter go to 0.
  - State goes to ST_LOW.
  - All outputs go to 0 immediately, without waiting for a clock edge.
- Synchroniser: s = last flop of a SYNC_STAGES-deep chain sampling IN_RAW_PULSE.
- FSM states:
  - ST_LOW: if s=1 and N=0, accept rise; if s=1 and N>0, set cnt=1 and go to ST_QUAL_HIGH.
  - ST_QUAL_HIGH: if s=0, set cnt=0 and return to ST_LOW (glitch discarded, no output). If s=1 and cnt>=N, accept rise. Otherwise cnt++.
  - ST_HIGH and ST_QUAL_LOW: mirror of the above with s=0, accepting a fall.
- Qualification rule:
  - A level change needs N+1 consecutive differing samples of s.
  - ">=" is used so that lowering N mid-qualification never deadlocks.
- Accept rise:
  - Go to ST_HIGH, set OUT_FILTERED_LEVEL=1, set cnt=0.
  - If the holdoff counter (value before this edge's update) is 0: OUT_RISE_PULSE=1 for one cycle, and load the holdoff counter with H.
  - If the holdoff counter is nonzero: OUT_REJECTED_PULSE=1 for one cycle, no rise pulse, no reload.
- Accept fall:
  - Go to ST_LOW, set OUT_FILTERED_LEVEL=0, OUT_FALL_PULSE=1 for one cycle, set cnt=0.
  - Falls are never subject to holdoff.
- Holdoff counter:
  - Decrements by 1 per cycle while nonzero; saturates at 0.
  - A reload on an edge takes priority over the decrement.
  - H=0 disables holdoff.
- Latency: if IN_RAW_PULSE is high before edge k and stays high, the level and strobe are registered on edge k+SYNC_STAGES+N.
- All pulse outputs and OUT_FILTERED_LEVEL are registered. Strobes are exactly one cycle wide, and at most one strobe is asserted per cycle.
- Reset released while raw is high: the FSM starts in ST_LOW, so a normal qualified rise (and OUT_RISE_PULSE) follows.
- Counter widths: cnt is FILTER_BITS wide and never exceeds N. The holdoff counter is HOLDOFF_BITS wide. No wrap-around is possible.

Decomposition:
- Package pulse_cond_pkg holds:
  - the 2-bit state encodings ST_LOW, ST_QUAL_HIGH, ST_HIGH, ST_QUAL_LOW;
  - the constant MIN_SYNC_STAGES=2.
- Sub-module pulse_sync_chain, parameterised by SYNC_STAGES, with asynchronous active-low reset to 0. The FSM, counters and output registers live in the top module.

Test Plan:
1. Hold IN_RESET_N=0 with raw toggling, then release with raw low -> all outputs stay 0; no strobes for 20 cycles.
2. N=3, H=0; raw high before edge 10 for 20 cycles, low before edge 30 -> OUT_FILTERED_LEVEL=1 and OUT_RISE_PULSE for one cycle after edge 15; level=0 and OUT_FALL_PULSE for one cycle after edge 35.
3. N=3; raw high before edges 10–12 only (three samples of s) -> no level change and no strobes.
4. N=0, H=0; raw high for one cycle before edge 10 -> rise pulse after edge 12, fall pulse after edge 13.
5. N=0, H=5; rises accepted at edges 12, 15 and 18 with falls between -> rise pulse at edge 12; rejected pulse only at edge 15 (counter=3); rise pulse at edge 18 (counter 0 since edge 17); level follows all three rises.
6. N=2, level high, raw held high; assert IN_RESET_N=0 mid-cycle -> level drops to 0 asynchronously. Release before edge k -> OUT_RISE_PULSE after edge k+4.
